// File: rtl/lsu_mem_access_pkg.sv
// rtl/lsu_mem_access_pkg.sv - load/store codes, bus widths and FSM encoding for the LSU
package lsu_mem_access_pkg;

  localparam int BUS_L_CODE = 3;
  localparam int BUS_S_CODE = 3;

  localparam logic [BUS_L_CODE-1:0] LOAD_NOPE = 3'd0;
  localparam logic [BUS_L_CODE-1:0] INSTR_LB  = 3'd1;
  localparam logic [BUS_L_CODE-1:0] INSTR_LH  = 3'd2;
  localparam logic [BUS_L_CODE-1:0] INSTR_LW  = 3'd3;
  localparam logic [BUS_L_CODE-1:0] INSTR_LBU = 3'd4;
  localparam logic [BUS_L_CODE-1:0] INSTR_LHU = 3'd5;

  localparam logic [BUS_S_CODE-1:0] STORE_NOPE = 3'd0;
  localparam logic [BUS_S_CODE-1:0] INSTR_SB   = 3'd1;
  localparam logic [BUS_S_CODE-1:0] INSTR_SH   = 3'd2;
  localparam logic [BUS_S_CODE-1:0] INSTR_SW   = 3'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

  // Access size class: 0 byte, 1 half, 2 word, 3 no access
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_NONE = 2'd3;

  function automatic logic [1:0] load_size(input logic [BUS_L_CODE-1:0] code);
    case (code)
      INSTR_LB, INSTR_LBU: load_size = SZ_BYTE;
      INSTR_LH, INSTR_LHU: load_size = SZ_HALF;
      INSTR_LW:            load_size = SZ_WORD;
      default:             load_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic [1:0] store_size(input logic [BUS_S_CODE-1:0] code);
    case (code)
      INSTR_SB: store_size = SZ_BYTE;
      INSTR_SH: store_size = SZ_HALF;
      INSTR_SW: store_size = SZ_WORD;
      default:  store_size = SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - byte/half extraction and sign/zero extension of a read word
module lsu_load_align
  import lsu_mem_access_pkg::*;
(
  input  logic [31:0]           rdata,
  input  logic [1:0]            off,
  input  logic [BUS_L_CODE-1:0] load_code,
  output logic [31:0]           data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? rdata[31:16] : rdata[15:0];
    case (load_code)
      INSTR_LB:  data = {{24{byte_v[7]}}, byte_v};
      INSTR_LBU: data = {24'd0, byte_v};
      INSTR_LH:  data = {{16{half_v[15]}}, half_v};
      INSTR_LHU: data = {16'd0, half_v};
      INSTR_LW:  data = rdata;
      default:   data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - EX->WB load/store unit with req/gnt/rvalid memory port
// Optional misaligned-access trap: LSU_MISALIGN_TRAP_EN
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BUS_L_CODE-1:0] load_code,
  input  logic [BUS_S_CODE-1:0] store_code,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [4:0]            rd_addr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  stall,
  output logic                  misalign
);

  lsu_state_e            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [4:0]            wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  misalign_q, misalign_d;
  logic [1:0]            off_q, off_d;
  logic [BUS_L_CODE-1:0] lcode_q, lcode_d;
  logic [4:0]            rd_q, rd_d;

  logic                  is_load;
  logic                  is_store;
  logic [1:0]            size;
  logic [1:0]            eff_off;
  logic                  trap;
  logic [DATA_W-1:0]     ld_data;

  lsu_load_align u_load_align (
    .rdata     (mem_rdata),
    .off       (off_q),
    .load_code (lcode_q),
    .data      (ld_data)
  );

  // A valid load code wins over any store code in the same request
  always_comb begin
    is_load  = (load_size(load_code) != SZ_NONE);
    is_store = !is_load && (store_size(store_code) != SZ_NONE);
    size     = is_load ? load_size(load_code) : store_size(store_code);
    case (size)
      SZ_WORD: eff_off = 2'b00;
      SZ_HALF: eff_off = {addr[1], 1'b0};
      default: eff_off = addr[1:0];
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    trap = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    wb_valid_d  = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    misalign_d  = 1'b0;
    off_d       = off_q;
    lcode_d     = lcode_q;
    rd_d        = rd_q;

    case (state_q)
      LSU_IDLE: begin
        if (req_valid && (is_load || is_store)) begin
          if (trap) begin
            misalign_d = 1'b1;
          end else begin
            state_d    = LSU_REQ;
            mem_req_d  = 1'b1;
            mem_we_d   = is_store;
            mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
            off_d      = eff_off;
            lcode_d    = is_load ? load_code : LOAD_NOPE;
            rd_d       = rd_addr;
            if (is_store) begin
              case (size)
                SZ_BYTE: begin
                  mem_wstrb_d = 4'b0001 << eff_off;
                  mem_wdata_d = {4{wr_data[7:0]}};
                end
                SZ_HALF: begin
                  mem_wstrb_d = 4'b0011 << eff_off;
                  mem_wdata_d = {2{wr_data[15:0]}};
                end
                default: begin
                  mem_wstrb_d = 4'hF;
                  mem_wdata_d = wr_data;
                end
              endcase
            end else begin
              mem_wstrb_d = 4'h0;
              mem_wdata_d = '0;
            end
          end
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? LSU_IDLE : LSU_RESP;
        end
      end
      LSU_RESP: begin
        if (mem_rvalid) begin
          state_d    = LSU_IDLE;
          wb_valid_d = (rd_q != 5'd0);
          wb_addr_d  = rd_q;
          wb_data_d  = ld_data;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= 4'h0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= '0;
      misalign_q  <= 1'b0;
      off_q       <= 2'b00;
      lcode_q     <= LOAD_NOPE;
      rd_q        <= 5'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      misalign_q  <= misalign_d;
      off_q       <= off_d;
      lcode_q     <= lcode_d;
      rd_q        <= rd_d;
    end
  end

  assign req_ready = (state_q == LSU_IDLE);
  assign stall     = (state_q != LSU_IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// tb/tb_lsu_mem_access.sv - directed and randomized checks of lsu_mem_access against a reference model
module tb_lsu_mem_access;
  import lsu_mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  load_code = 3'd0;
  logic [2:0]  store_code = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wr_data = 32'd0;
  logic [4:0]  rd_addr = 5'd0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall, misalign;

  int checks = 0;
  int errors = 0;

  lsu_mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .load_code(load_code), .store_code(store_code), .addr(addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Access width in bytes; loads take precedence, 0 means no access
  function automatic int nbytes(input logic [2:0] lc, input logic [2:0] sc);
    if (lc == INSTR_LB || lc == INSTR_LBU) return 1;
    if (lc == INSTR_LH || lc == INSTR_LHU) return 2;
    if (lc == INSTR_LW) return 4;
    if (sc == INSTR_SB) return 1;
    if (sc == INSTR_SH) return 2;
    if (sc == INSTR_SW) return 4;
    return 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] lc, input logic [31:0] rdata,
                                           input logic [31:0] ea);
    logic [31:0] v;
    v = rdata >> (8 * (ea % 4));
    case (lc)
      INSTR_LB:  begin v = v & 32'hFF;   if (v >= 32'h80)   v = v + 32'hFFFFFF00; end
      INSTR_LBU: v = v & 32'hFF;
      INSTR_LH:  begin v = v & 32'hFFFF; if (v >= 32'h8000) v = v + 32'hFFFF0000; end
      INSTR_LHU: v = v & 32'hFFFF;
      default:   v = rdata;
    endcase
    return v;
  endfunction

  task automatic access(input logic [2:0] lc, input logic [2:0] sc, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd, input int gd,
                        input int rvd, input logic [31:0] rdat, input bit junk);
    int nb;
    bit is_ld, is_st, mis;
    logic [31:0] ea, wa;
    nb    = nbytes(lc, sc);
    is_ld = (nb != 0) && (lc != LOAD_NOPE);
    is_st = (nb != 0) && !is_ld;
    @(negedge clk);
    chk("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; load_code = lc; store_code = sc; addr = a; wr_data = wd; rd_addr = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; load_code = 3'd0; store_code = 3'd0; addr = $urandom; wr_data = $urandom;
    rd_addr = 5'($urandom);
    if (nb == 0) begin
      chk("nop_mem_req", {31'd0, mem_req}, 32'd0);
      chk("nop_stall", {31'd0, stall}, 32'd0);
      return;
    end
    mis = (a % nb) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) begin
      chk("trap_misalign", {31'd0, misalign}, 32'd1);
      chk("trap_mem_req", {31'd0, mem_req}, 32'd0);
      chk("trap_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      chk("trap_pulse_end", {31'd0, misalign}, 32'd0);
      return;
    end
`endif
    ea = a - (a % nb);
    wa = ea - (ea % 4);
    chk("mem_req", {31'd0, mem_req}, 32'd1);
    chk("mem_we", {31'd0, mem_we}, {31'd0, is_st});
    chk("mem_addr", mem_addr, wa);
    chk("misalign_off", {31'd0, misalign}, 32'd0);
    chk("stall_req", {31'd0, stall}, 32'd1);
    if (is_st) begin
      chk("mem_wstrb", {28'd0, mem_wstrb}, ((32'd1 << nb) - 32'd1) << (ea % 4));
      if (nb == 1)      chk("mem_wdata_b", mem_wdata, (wd & 32'hFF) * 32'h01010101);
      else if (nb == 2) chk("mem_wdata_h", mem_wdata, (wd & 32'hFFFF) * 32'h00010001);
      else              chk("mem_wdata_w", mem_wdata, wd);
    end else begin
      chk("mem_wstrb_ld", {28'd0, mem_wstrb}, 32'd0);
    end
    for (int i = 0; i < gd; i++) begin
      mem_rvalid = junk ? 1'($urandom) : 1'b0;
      mem_rdata  = $urandom;
      @(posedge clk); #1;
      chk("req_hold", {31'd0, mem_req}, 32'd1);
      chk("addr_hold", mem_addr, wa);
      chk("stall_wait_gnt", {31'd0, stall}, 32'd1);
      chk("no_wb_in_req", {31'd0, wb_valid}, 32'd0);
    end
    mem_rvalid = 1'b0;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("req_drop", {31'd0, mem_req}, 32'd0);
    if (is_st) begin
      chk("st_ready", {31'd0, req_ready}, 32'd1);
      chk("st_stall", {31'd0, stall}, 32'd0);
      chk("st_no_wb", {31'd0, wb_valid}, 32'd0);
      return;
    end
    chk("stall_resp", {31'd0, stall}, 32'd1);
    for (int i = 0; i < rvd; i++) begin
      @(posedge clk); #1;
      chk("stall_wait_rv", {31'd0, stall}, 32'd1);
      chk("no_wb_wait", {31'd0, wb_valid}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdat;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, rd != 5'd0});
    chk("stall_done", {31'd0, stall}, 32'd0);
    if (rd != 5'd0) begin
      chk("wb_addr", {27'd0, wb_addr}, {27'd0, rd});
      chk("wb_data", wb_data, exp_load(lc, rdat, ea));
    end
    @(posedge clk); #1;
    chk("wb_pulse_end", {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] lcs[6];
    logic [2:0] scs[4];
    lcs = '{LOAD_NOPE, INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    scs = '{STORE_NOPE, INSTR_SB, INSTR_SH, INSTR_SW};

    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    access(LOAD_NOPE, INSTR_SW, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 32'd0, 1'b0);
    access(LOAD_NOPE, INSTR_SB, 32'h103, 32'h000000A5, 5'd0, 0, 0, 32'd0, 1'b0);
    access(INSTR_LB,  STORE_NOPE, 32'h102, 32'd0, 5'd5, 0, 0, 32'h0080FF00, 1'b0);
    access(INSTR_LBU, STORE_NOPE, 32'h102, 32'd0, 5'd5, 0, 0, 32'h0080FF00, 1'b0);
    access(INSTR_LH,  STORE_NOPE, 32'h200, 32'd0, 5'd9, 2, 3, 32'h1234_8001, 1'b1);
    access(INSTR_LW,  STORE_NOPE, 32'h202, 32'd0, 5'd7, 0, 0, 32'hCAFE_F00D, 1'b0);
    access(LOAD_NOPE, STORE_NOPE, 32'h300, 32'd1, 5'd3, 0, 0, 32'd0, 1'b0);
    access(INSTR_LHU, INSTR_SW, 32'h402, 32'h5555_5555, 5'd12, 1, 0, 32'hBEEF_0000, 1'b0);
    access(INSTR_LW,  STORE_NOPE, 32'h500, 32'd0, 5'd0, 0, 1, 32'h1111_2222, 1'b0);

    // Reset while waiting for the read response
    @(negedge clk);
    req_valid = 1'b1; load_code = INSTR_LW; addr = 32'h600; rd_addr = 5'd4;
    @(posedge clk); #1;
    req_valid = 1'b0; load_code = LOAD_NOPE;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    @(negedge clk); rst = 1'b1; #1;
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_addr", mem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    chk("post_rst_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("post_rst_wb_data", wb_data, 32'd0);
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    for (int n = 0; n < 80; n++) begin
      access(lcs[$urandom_range(0, 5)], scs[$urandom_range(0, 3)],
             32'($urandom_range(0, 32'hFFFF)), $urandom, 5'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
